convolutor_addr_sched: RTL and testbench

Address and loop scheduler for the convolution datapath, computing z[n] = sum over k of x[k]*y[n-k].
- Sequences the X and Y memory reads, accumulator clear/enable and Z writes.
- Sits between the host start/size registers and the memories plus MAC.
- Replaces ad-hoc enable decoding with one deterministic per-output-sample loop.

---
 rtl/convolutor_pkg.sv | 17 +
 rtl/convolutor_addr_sched_if.sv | 31 +++
 rtl/convolutor_delay_line.sv | 31 +++
 rtl/convolutor_addr_sched.sv | 188 ++++++++++++++++++
 tb/tb_convolutor_addr_sched.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/convolutor_pkg.sv
// Shared types and defaults for the convolution address/loop scheduler.
package convolutor_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRead,
    StDrain,
    StWrite,
    StDone
  } sched_state_e;

  localparam int unsigned RdLatDefault  = 1;
  localparam int unsigned MacLatDefault = 1;
  localparam int unsigned CYCLE_CNT_W   = 16;

endpackage

// File: rtl/convolutor_addr_sched_if.sv
// Host/memory/MAC-side signal bundle of the convolution scheduler.
interface convolutor_addr_sched_if #(
  parameter int unsigned ADDR_W = 5
) ();

  logic              start_i;
  logic [ADDR_W:0]   size_x_i;
  logic [ADDR_W:0]   size_y_i;
  logic [ADDR_W-1:0] mem_x_addr_o;
  logic [ADDR_W-1:0] mem_y_addr_o;
  logic              mem_rd_o;
  logic              acc_clr_o;
  logic              acc_en_o;
  logic [ADDR_W:0]   z_addr_o;
  logic              z_write_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    input  start_i, size_x_i, size_y_i,
    output mem_x_addr_o, mem_y_addr_o, mem_rd_o, acc_clr_o, acc_en_o,
    output z_addr_o, z_write_o, busy_o, done_o
  );

  modport slave (
    output start_i, size_x_i, size_y_i,
    input  mem_x_addr_o, mem_y_addr_o, mem_rd_o, acc_clr_o, acc_en_o,
    input  z_addr_o, z_write_o, busy_o, done_o
  );

endinterface

// File: rtl/convolutor_delay_line.sv
// Fixed-depth shift register with asynchronous clear; aligns read strobes with memory data.
module convolutor_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

  always_comb begin
    stage_d[0] = din_i;
    for (int i = 1; i < int'(DEPTH); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/convolutor_addr_sched.sv
// Per-output-sample loop scheduler for z[n] = sum x[k]*y[n-k].
// Optional busy-cycle counter port enabled by CONVOLUTOR_CYCLE_CNT_EN.
module convolutor_addr_sched
  import convolutor_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned RD_LAT  = RdLatDefault,
  parameter int unsigned MAC_LAT = MacLatDefault
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef CONVOLUTOR_CYCLE_CNT_EN
  output logic [CYCLE_CNT_W-1:0] cycle_cnt_o,
`endif
  convolutor_addr_sched_if.master bus
);

  localparam int unsigned DrainCycles = RD_LAT + MAC_LAT;

  sched_state_e      state_q, state_d;
  logic [ADDR_W:0]   size_x_q, size_x_d, size_y_q, size_y_d, n_q, n_d;
  logic [ADDR_W+1:0] size_z_q, size_z_d, n_p1;
  logic [ADDR_W-1:0] k_q, k_d, k_hi_q, k_hi_d;
  logic [2:0]        drain_q, drain_d;
  logic              first_q, first_d;

  // Outputs are registered from the current state, so they trail it by one cycle.
  logic [ADDR_W-1:0] x_addr_q, x_addr_d, y_addr_q, y_addr_d;
  logic [ADDR_W:0]   z_addr_q, z_addr_d;
  logic              rd_q, rd_d, clr_tag_q, clr_tag_d, zw_q, zw_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [1:0]        acc_bits;

  always_comb begin
    state_d  = state_q;
    size_x_d = size_x_q;
    size_y_d = size_y_q;
    size_z_d = size_z_q;
    n_d      = n_q;
    k_d      = k_q;
    k_hi_d   = k_hi_q;
    drain_d  = drain_q;
    first_d  = first_q;
    n_p1     = {1'b0, n_q} + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          size_x_d = bus.size_x_i;
          size_y_d = bus.size_y_i;
          size_z_d = {1'b0, bus.size_x_i} + {1'b0, bus.size_y_i} - 1'b1;
          n_d      = '0;
          state_d  = StInit;
        end
      end
      StInit: begin
        if (size_x_q == '0 || size_y_q == '0) begin
          state_d = StDone;
        end else begin
          // Unsigned form of max(0, n-size_y+1); never forms a negative difference.
          k_d     = (n_p1 >= {1'b0, size_y_q}) ? ADDR_W'(n_p1 - {1'b0, size_y_q}) : '0;
          k_hi_d  = (n_q < size_x_q) ? n_q[ADDR_W-1:0] : ADDR_W'(size_x_q - 1'b1);
          first_d = 1'b1;
          state_d = StRead;
        end
      end
      StRead: begin
        first_d = 1'b0;
        if (k_q == k_hi_q) begin
          drain_d = '0;
          state_d = StDrain;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == 3'(DrainCycles - 1)) begin
          state_d = StWrite;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StWrite: begin
        if (n_p1 == size_z_q) begin
          state_d = StDone;
        end else begin
          n_d     = n_q + 1'b1;
          state_d = StInit;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    rd_d      = (state_q == StRead);
    x_addr_d  = rd_d ? k_q : '0;
    y_addr_d  = rd_d ? ADDR_W'(n_q - {1'b0, k_q}) : '0;
    clr_tag_d = rd_d & first_q;
    zw_d      = (state_q == StWrite);
    z_addr_d  = zw_d ? n_q : '0;
    busy_d    = (state_q == StInit) || rd_d || (state_q == StDrain) || zw_d;
    done_d    = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      size_x_q  <= '0;
      size_y_q  <= '0;
      size_z_q  <= '0;
      n_q       <= '0;
      k_q       <= '0;
      k_hi_q    <= '0;
      drain_q   <= '0;
      first_q   <= 1'b0;
      x_addr_q  <= '0;
      y_addr_q  <= '0;
      z_addr_q  <= '0;
      rd_q      <= 1'b0;
      clr_tag_q <= 1'b0;
      zw_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_x_q  <= size_x_d;
      size_y_q  <= size_y_d;
      size_z_q  <= size_z_d;
      n_q       <= n_d;
      k_q       <= k_d;
      k_hi_q    <= k_hi_d;
      drain_q   <= drain_d;
      first_q   <= first_d;
      x_addr_q  <= x_addr_d;
      y_addr_q  <= y_addr_d;
      z_addr_q  <= z_addr_d;
      rd_q      <= rd_d;
      clr_tag_q <= clr_tag_d;
      zw_q      <= zw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  convolutor_delay_line #(
    .DEPTH (RD_LAT),
    .WIDTH (2)
  ) u_acc_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  ({clr_tag_q, rd_q}),
    .dout_o (acc_bits)
  );

`ifdef CONVOLUTOR_CYCLE_CNT_EN
  logic [CYCLE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle && bus.start_i) begin
      cnt_d = '0;
    end else if (busy_q && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cycle_cnt_o = cnt_q;
`endif

  assign bus.mem_x_addr_o = x_addr_q;
  assign bus.mem_y_addr_o = y_addr_q;
  assign bus.mem_rd_o     = rd_q;
  assign bus.acc_en_o     = acc_bits[0];
  assign bus.acc_clr_o    = acc_bits[1];
  assign bus.z_addr_o     = z_addr_q;
  assign bus.z_write_o    = zw_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;

endmodule

// File: tb/tb_convolutor_addr_sched.sv
// Directed bench for convolutor_addr_sched with an external memory/MAC model.
module tb_convolutor_addr_sched;
  import convolutor_pkg::*;

  localparam int unsigned AW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  convolutor_addr_sched_if #(.ADDR_W(AW)) bus ();

`ifdef CONVOLUTOR_CYCLE_CNT_EN
  logic [CYCLE_CNT_W-1:0] cycle_cnt;
`endif

  convolutor_addr_sched #(
    .ADDR_W  (AW),
    .RD_LAT  (1),
    .MAC_LAT (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef CONVOLUTOR_CYCLE_CNT_EN
    .cycle_cnt_o (cycle_cnt),
`endif
    .bus         (bus)
  );

  int errors = 0;
  int checks = 0;

  // Memories (1-cycle read) and accumulator (1-cycle MAC) around the scheduler.
  int xmem [32];
  int ymem [32];
  int zmem [64];
  int rx = 0, ry = 0, acc = 0;

  always @(posedge clk) begin
    if (bus.mem_rd_o) begin
      rx <= xmem[bus.mem_x_addr_o];
      ry <= ymem[bus.mem_y_addr_o];
    end
    if (bus.acc_en_o) acc <= (bus.acc_clr_o ? 0 : acc) + rx * ry;
    if (bus.z_write_o) zmem[bus.z_addr_o] <= acc;
  end

  int rd_x[$], rd_y[$], zw_addr[$];
  bit en_clr[$];
  int done_cyc, rd_sum_bad;

  function automatic int activity();
    return int'(bus.mem_rd_o | bus.acc_en_o | bus.z_write_o | bus.busy_o | bus.done_o);
  endfunction

  // Accept one job and log DUT activity; cycle c = sample after the (c)th edge past accept.
  task automatic run_job(input logic [AW:0] sx, input logic [AW:0] sy, input int budget,
                         input bit hold_start);
    rd_x.delete(); rd_y.delete(); zw_addr.delete(); en_clr.delete();
    done_cyc = -1;
    rd_sum_bad = 0;
    @(negedge clk);
    bus.size_x_i = sx;
    bus.size_y_i = sy;
    bus.start_i  = 1'b1;
    @(posedge clk);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!hold_start) bus.start_i = 1'b0;
      if (bus.mem_rd_o) begin
        rd_x.push_back(int'(bus.mem_x_addr_o));
        rd_y.push_back(int'(bus.mem_y_addr_o));
        if (int'(bus.mem_x_addr_o) + int'(bus.mem_y_addr_o) != zw_addr.size()) rd_sum_bad++;
      end
      if (bus.acc_en_o) en_clr.push_back(bus.acc_clr_o);
      if (bus.z_write_o) zw_addr.push_back(int'(bus.z_addr_o));
      if (bus.done_o) begin
        done_cyc = c;
        bus.start_i = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int act;
    bus.start_i  = 1'b1;
    bus.size_x_i = 3;
    bus.size_y_i = 2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.mem_rd_o, bus.acc_en_o, bus.acc_clr_o, bus.z_write_o, bus.busy_o, bus.done_o,
         bus.mem_x_addr_o, bus.mem_y_addr_o, bus.z_addr_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%b en=%b clr=%b zw=%b busy=%b done=%b x=%0d y=%0d z=%0d want all 0",
               bus.mem_rd_o, bus.acc_en_o, bus.acc_clr_o, bus.z_write_o, bus.busy_o,
               bus.done_o, bus.mem_x_addr_o, bus.mem_y_addr_o, bus.z_addr_o);
    end
    bus.start_i = 1'b0;
    rst_n = 1'b1;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      act += activity();
    end
    checks++;
    if (act !== 0) begin
      errors++;
      $display("FAIL reset_idle: got %0d active cycles want 0", act);
    end
  endtask

  task automatic test_basic();
    int exp_x[6] = '{0, 0, 1, 1, 2, 2};
    int exp_y[6] = '{0, 1, 0, 1, 0, 1};
    int exp_z[4] = '{4, 13, 22, 15};
    int pat;
    xmem[0] = 1; xmem[1] = 2; xmem[2] = 3;
    ymem[0] = 4; ymem[1] = 5;
    run_job(3, 2, 60, 1'b0);
    checks++;
    if (done_cyc !== 23) begin
      errors++;
      $display("FAIL basic_done_cycle: got %0d want 23", done_cyc);
    end
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_at_done: got %b want 0", bus.busy_o);
    end
    checks++;
    if (rd_x.size() !== 6) begin
      errors++;
      $display("FAIL basic_read_count: got %0d want 6", rd_x.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rd_x[i] !== exp_x[i] || rd_y[i] !== exp_y[i]) begin
          errors++;
          $display("FAIL basic_read%0d: got (%0d,%0d) want (%0d,%0d)",
                   i, rd_x[i], rd_y[i], exp_x[i], exp_y[i]);
        end
      end
    end
    checks++;
    if (zw_addr.size() !== 4) begin
      errors++;
      $display("FAIL basic_zwrite_count: got %0d want 4", zw_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (zw_addr[i] !== i) begin
          errors++;
          $display("FAIL basic_zaddr%0d: got %0d want %0d", i, zw_addr[i], i);
        end
      end
    end
    pat = 0;
    foreach (en_clr[i]) pat = (pat << 1) | int'(en_clr[i]);
    checks++;
    if (en_clr.size() !== 6 || pat !== 'b110101) begin
      errors++;
      $display("FAIL basic_acc_clr: got %0d enables pattern %b want 6 enables pattern 110101",
               en_clr.size(), pat);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (zmem[i] !== exp_z[i]) begin
        errors++;
        $display("FAIL basic_golden_z%0d: got %0d want %0d", i, zmem[i], exp_z[i]);
      end
    end
`ifdef CONVOLUTOR_CYCLE_CNT_EN
    checks++;
    if (cycle_cnt !== 16'd22) begin
      errors++;
      $display("FAIL basic_cycle_cnt: got %0d want 22", cycle_cnt);
    end
`endif
  endtask

  task automatic test_zero_size();
    run_job(0, 7, 20, 1'b0);
    checks++;
    if (done_cyc !== 2) begin
      errors++;
      $display("FAIL zero_done_cycle: got %0d want 2", done_cyc);
    end
    checks++;
    if (rd_x.size() !== 0 || zw_addr.size() !== 0) begin
      errors++;
      $display("FAIL zero_no_access: got %0d reads %0d writes want 0 0",
               rd_x.size(), zw_addr.size());
    end
  endtask

  task automatic test_max_size();
    int bad, zexp;
    for (int i = 0; i < 32; i++) begin
      xmem[i] = i + 1;
      ymem[i] = (3 * i + 1) % 7;
    end
    run_job(32, 32, 3000, 1'b0);
    checks++;
    if (done_cyc !== 1277) begin
      errors++;
      $display("FAIL max_done_cycle: got %0d want 1277", done_cyc);
    end
    checks++;
    if (zw_addr.size() !== 63 || (zw_addr.size() > 0 && zw_addr[$] !== 62)) begin
      errors++;
      $display("FAIL max_zwrites: got %0d writes last %0d want 63 writes last 62",
               zw_addr.size(), (zw_addr.size() > 0) ? zw_addr[$] : -1);
    end
    checks++;
    if (rd_x.size() !== 1024 || rd_sum_bad !== 0) begin
      errors++;
      $display("FAIL max_reads: got %0d reads %0d with x+y!=n want 1024 reads 0 bad",
               rd_x.size(), rd_sum_bad);
    end
    bad = 0;
    for (int n = 0; n < 63; n++) begin
      zexp = 0;
      for (int k = 0; k < 32; k++) if (n - k >= 0 && n - k < 32) zexp += xmem[k] * ymem[n - k];
      if (zmem[n] !== zexp) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL max_golden_z: got %0d wrong Z words want 0", bad);
    end
  endtask

  task automatic test_reset_restart();
    int zw_seen, act;
    bit found, saw_done;
    xmem[0] = 1; xmem[1] = 2; xmem[2] = 3;
    ymem[0] = 4; ymem[1] = 5;
    found = 1'b0;
    saw_done = 1'b0;
    zw_seen = 0;
    @(negedge clk);
    bus.size_x_i = 3;
    bus.size_y_i = 2;
    bus.start_i  = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      if (bus.z_write_o) zw_seen++;
      if (bus.mem_rd_o && zw_seen == 2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL restart_reach_n2: got no READ of n=2 within 40 cycles want one");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_rd_o, bus.acc_en_o, bus.acc_clr_o, bus.z_write_o, bus.busy_o, bus.done_o,
         bus.mem_x_addr_o, bus.mem_y_addr_o, bus.z_addr_o} !== '0) begin
      errors++;
      $display("FAIL restart_async_clear: got rd=%b en=%b zw=%b busy=%b done=%b want all 0",
               bus.mem_rd_o, bus.acc_en_o, bus.z_write_o, bus.busy_o, bus.done_o);
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.done_o || bus.z_write_o) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.done_o || bus.z_write_o) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL restart_no_done: got done_o or z_write_o after reset want none");
    end
    xmem[0] = 6;
    ymem[0] = 7;
    run_job(1, 1, 40, 1'b1);
    checks++;
    if (done_cyc !== 6) begin
      errors++;
      $display("FAIL restart_done_cycle: got %0d want 6", done_cyc);
    end
    checks++;
    if (rd_x.size() !== 1 || (rd_x.size() == 1 && (rd_x[0] !== 0 || rd_y[0] !== 0))) begin
      errors++;
      $display("FAIL restart_reads: got %0d reads want exactly one read (0,0)", rd_x.size());
    end
    checks++;
    if (zw_addr.size() !== 1 || (zw_addr.size() == 1 && zw_addr[0] !== 0) || zmem[0] !== 42) begin
      errors++;
      $display("FAIL restart_zwrite: got %0d writes z[0]=%0d want 1 write at 0 with 42",
               zw_addr.size(), zmem[0]);
    end
    act = 0;
    repeat (5) begin
      @(negedge clk);
      act += activity();
    end
    checks++;
    if (act !== 0) begin
      errors++;
      $display("FAIL restart_idle_after: got %0d active cycles want 0", act);
    end
  endtask

  initial begin
    bus.start_i  = 1'b0;
    bus.size_x_i = '0;
    bus.size_y_i = '0;
    test_reset();
    test_basic();
    test_zero_size();
    test_max_size();
    test_reset_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
